// File: rtl/pcpi_mm_sequencer_pkg.sv
// Shared encodings for the PCPI matrix-multiply sequencer and its instruction decoder.
package pcpi_mm_sequencer_pkg;

  localparam logic [6:0] OPC_CUSTOM = 7'b1011011;

  localparam logic [2:0] F3_CFG     = 3'b000;
  localparam logic [2:0] F3_LOAD    = 3'b001;
  localparam logic [2:0] F3_WEIGHT  = 3'b010;
  localparam logic [2:0] F3_COMPUTE = 3'b100;
  localparam logic [2:0] F3_READ    = 3'b101;
  localparam logic [2:0] F3_STATUS  = 3'b110;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXEC   = 3'd1;
  localparam logic [2:0] ST_RDWAIT = 3'd2;
  localparam logic [2:0] ST_ENG    = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;
  localparam logic [2:0] ST_GUARD  = 3'd5;

  localparam int STAT_ERR_TO   = 0;
  localparam int STAT_ERR_CFG  = 1;
  localparam int STAT_ERR_ADDR = 2;
  localparam int STAT_DIM_LSB  = 8;

  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic cfg;
    logic load;
    logic weight;
    logic compute;
    logic read;
    logic status;
  } op_onehot_t;

  function automatic logic [31:0] status_word(input logic [7:0] dim,
                                              input logic       err_addr,
                                              input logic       err_cfg,
                                              input logic       err_to);
    logic [31:0] w;
    w                       = '0;
    w[STAT_DIM_LSB +: 8]    = dim;
    w[STAT_ERR_ADDR]        = err_addr;
    w[STAT_ERR_CFG]         = err_cfg;
    w[STAT_ERR_TO]          = err_to;
    return w;
  endfunction

endpackage

// File: rtl/pcpi_mm_sequencer_if.sv
// PCPI handshake bundle between the CPU (master) and a coprocessor front-end (slave).
interface pcpi_mm_sequencer_if;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

endinterface

// File: rtl/pcpi_mm_sequencer_insn_decode.sv
// Combinational PCPI custom-opcode match with one-hot funct3 decode; unclaimed funct3 never matches.
module pcpi_insn_decode
  import pcpi_mm_sequencer_pkg::*;
#(
  parameter logic [6:0] FUNCT7 = 7'b0000001
) (
  input  logic        valid,
  input  logic [31:0] insn,
  output logic        match,
  output op_onehot_t  op
);

  logic unused_fields;
  assign unused_fields = ^{insn[24:15], insn[11:7]};

  always_comb begin
    op = '0;
    case (insn[14:12])
      F3_CFG:     op.cfg     = 1'b1;
      F3_LOAD:    op.load    = 1'b1;
      F3_WEIGHT:  op.weight  = 1'b1;
      F3_COMPUTE: op.compute = 1'b1;
      F3_READ:    op.read    = 1'b1;
      F3_STATUS:  op.status  = 1'b1;
      default:    ;
    endcase
  end

  assign match = valid && (insn[6:0] == OPC_CUSTOM) && (insn[31:25] == FUNCT7) && (|op);

endmodule

// File: rtl/pcpi_mm_sequencer.sv
// PCPI front-end for the matrix-multiply coprocessor: decodes custom instructions and
// sequences scratchpad and systolic-engine handshakes through one registered FSM.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a matching instruction; latches operands on match
// ST_EXEC   | one-cycle action: strobe scratchpad, start engine, or update cfg
// ST_RDWAIT | scratchpad read data lands and is registered
// ST_ENG    | waiting for eng_done or timeout
// ST_RESP   | pcpi_ready (and write-back if any) for exactly one cycle
// ST_GUARD  | one dead cycle so the CPU can drop pcpi_valid
module pcpi_mm_sequencer
  import pcpi_mm_sequencer_pkg::*;
#(
  parameter int         DWIDTH      = 16,
  parameter int         AWIDTH      = 8,
  parameter int         DEPTH       = 256,
  parameter int         PE_DIM      = 4,
  parameter logic [6:0] FUNCT7      = 7'b0000001,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  pcpi_mm_sequencer_if.slave            pcpi,
  output logic                          sp_we,
  output logic                          sp_re,
  output logic [AWIDTH-1:0]             sp_addr,
  output logic [DWIDTH-1:0]             sp_wdata,
  input  logic [DWIDTH-1:0]             sp_rdata,
  output logic                          eng_start,
  output logic                          eng_op,
  output logic [$clog2(PE_DIM+1)-1:0]   eng_dim,
  input  logic                          eng_done
);

  localparam int               DIM_W    = $clog2(PE_DIM + 1);
  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state;
  op_onehot_t        op_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              oob_q;
  logic              cfg_ok_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DIM_W-1:0]  dim_q;
  logic              err_addr;
  logic              err_cfg;
  logic              err_to;

  logic              hit;
  op_onehot_t        hit_op;

  logic              unused_rs2;
  assign unused_rs2 = ^pcpi.pcpi_rs2;

  pcpi_insn_decode #(.FUNCT7(FUNCT7)) u_decode (
    .valid (pcpi.pcpi_valid),
    .insn  (pcpi.pcpi_insn),
    .match (hit),
    .op    (hit_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oob_q    <= 1'b0;
      cfg_ok_q <= 1'b0;
      rdata_q  <= '0;
      cnt      <= '0;
      dim_q    <= DIM_W'(PE_DIM);
      err_addr <= 1'b0;
      err_cfg  <= 1'b0;
      err_to   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            op_q     <= hit_op;
            addr_q   <= pcpi.pcpi_rs1[AWIDTH-1:0];
            wdata_q  <= pcpi.pcpi_rs2[DWIDTH-1:0];
            oob_q    <= (pcpi.pcpi_rs1 >= 32'(DEPTH));
            // Range check on the full operand so large values never alias into 1..PE_DIM.
            cfg_ok_q <= (pcpi.pcpi_rs1 != 32'd0) && (pcpi.pcpi_rs1 <= 32'(PE_DIM));
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= '0;
          if ((op_q.load || op_q.read) && oob_q)
            err_addr <= 1'b1;
          if (op_q.cfg) begin
            dim_q <= cfg_ok_q ? DIM_W'(addr_q) : DIM_W'(PE_DIM);
            if (!cfg_ok_q)
              err_cfg <= 1'b1;
          end
          if (op_q.read)
            state <= ST_RDWAIT;
          else if (op_q.weight || op_q.compute)
            state <= ST_ENG;
          else
            state <= ST_RESP;
        end
        ST_RDWAIT: begin
          rdata_q <= oob_q ? ERR_WORD : 32'(sp_rdata);
          state   <= ST_RESP;
        end
        ST_ENG: begin
          if (eng_done) begin
            state <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            err_to <= 1'b1;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (op_q.status) begin
            err_addr <= 1'b0;
            err_cfg  <= 1'b0;
            err_to   <= 1'b0;
          end
          state <= ST_GUARD;
        end
        ST_GUARD: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so an async reset forces them low at once.
  always_comb begin
    sp_we           = 1'b0;
    sp_re           = 1'b0;
    eng_start       = 1'b0;
    eng_op          = 1'b0;
    pcpi.pcpi_wait  = 1'b0;
    pcpi.pcpi_ready = 1'b0;
    pcpi.pcpi_wr    = 1'b0;
    pcpi.pcpi_rd    = '0;
    case (state)
      ST_EXEC: begin
        pcpi.pcpi_wait = 1'b1;
        sp_we          = op_q.load && !oob_q;
        sp_re          = op_q.read && !oob_q;
        eng_start      = op_q.weight || op_q.compute;
        eng_op         = op_q.compute;
      end
      ST_RDWAIT: pcpi.pcpi_wait = 1'b1;
      ST_ENG: begin
        pcpi.pcpi_wait = 1'b1;
        eng_op         = op_q.compute;
      end
      ST_RESP: begin
        pcpi.pcpi_ready = 1'b1;
        if (op_q.read) begin
          pcpi.pcpi_wr = 1'b1;
          pcpi.pcpi_rd = rdata_q;
        end else if (op_q.status) begin
          pcpi.pcpi_wr = 1'b1;
          pcpi.pcpi_rd = status_word(8'(dim_q), err_addr, err_cfg, err_to);
        end
      end
      default: ;
    endcase
  end

  assign sp_addr  = addr_q;
  assign sp_wdata = wdata_q;
  assign eng_dim  = dim_q;

endmodule

// File: tb/tb_pcpi_mm_sequencer.sv
// Randomized self-checking bench for pcpi_mm_sequencer against a transaction-level model.
module tb_pcpi_mm_sequencer;

  localparam int DEPTH  = 256;
  localparam int PE_DIM = 4;
  localparam int TO_CYC = 16;

  localparam logic [2:0] C_CFG = 3'b000, C_LOAD = 3'b001, C_WEIGHT = 3'b010,
                         C_COMPUTE = 3'b100, C_READ = 3'b101, C_STATUS = 3'b110;

  logic        clk;
  logic        rst;
  logic        sp_we, sp_re;
  logic [7:0]  sp_addr;
  logic [15:0] sp_wdata;
  logic [15:0] sp_rdata;
  logic        eng_start, eng_op;
  logic [2:0]  eng_dim;
  logic        eng_done;

  pcpi_mm_sequencer_if bus ();

  pcpi_mm_sequencer #(
    .DWIDTH(16), .AWIDTH(8), .DEPTH(DEPTH), .PE_DIM(PE_DIM),
    .FUNCT7(7'b0000001), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .pcpi(bus),
    .sp_we(sp_we), .sp_re(sp_re), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
    .sp_rdata(sp_rdata), .eng_start(eng_start), .eng_op(eng_op),
    .eng_dim(eng_dim), .eng_done(eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad stand-in: one-cycle read latency.
  bit [15:0] ram [256];
  always @(posedge clk) begin
    if (sp_we) ram[sp_addr] <= sp_wdata;
    if (sp_re) sp_rdata <= ram[sp_addr];
  end

  // Reference model state.
  int        m_dim;
  bit        m_ea, m_ec, m_et;
  bit [15:0] ref_mem [256];

  int n_chk;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b1011011};
  endfunction

  task automatic model_reset();
    m_dim = PE_DIM;
    m_ea  = 0;
    m_ec  = 0;
    m_et  = 0;
  endtask

  // done_dly: cycles after eng_start at which eng_done is pulsed; 0 = never.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rs2, input int done_dly);
    int          exp_lat, exp_we, exp_re, exp_st;
    bit          exp_wr, exp_op;
    logic [31:0] exp_rd;
    int          cyc, lat, we_n, re_n, st_n, done_at, wait_bad, quiet_bad, addr_bad;
    bit          got, wr_seen, op_seen;
    logic [31:0] rd_seen;

    exp_lat = 2; exp_we = 0; exp_re = 0; exp_st = 0;
    exp_wr = 0; exp_rd = 0; exp_op = (f3 == C_COMPUTE);
    case (f3)
      C_CFG: begin
        if (rs1 >= 1 && rs1 <= PE_DIM) m_dim = int'(rs1);
        else begin m_dim = PE_DIM; m_ec = 1; end
      end
      C_LOAD: begin
        if (rs1 < DEPTH) begin exp_we = 1; ref_mem[rs1[7:0]] = rs2[15:0]; end
        else m_ea = 1;
      end
      C_READ: begin
        exp_lat = 3; exp_wr = 1;
        if (rs1 < DEPTH) begin exp_re = 1; exp_rd = {16'h0, ref_mem[rs1[7:0]]}; end
        else begin exp_rd = 32'hFFFF_FFFF; m_ea = 1; end
      end
      C_STATUS: begin
        exp_wr = 1;
        exp_rd = 32'(m_dim * 256 + int'(m_ea) * 4 + int'(m_ec) * 2 + int'(m_et));
        m_ea = 0; m_ec = 0; m_et = 0;
      end
      default: begin
        exp_st = 1;
        if (done_dly >= 1 && done_dly <= TO_CYC) exp_lat = 2 + done_dly;
        else begin exp_lat = 2 + TO_CYC; m_et = 1; end
      end
    endcase

    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk_insn(f3);
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    cyc = 0; lat = -1; we_n = 0; re_n = 0; st_n = 0; done_at = -1;
    wait_bad = 0; quiet_bad = 0; addr_bad = 0;
    got = 0; wr_seen = 0; op_seen = 0; rd_seen = 0;
    while (!got && cyc < 60) begin
      step();
      cyc++;
      eng_done = 1'b0;
      if (bus.pcpi_ready) begin
        got = 1; lat = cyc; wr_seen = bus.pcpi_wr; rd_seen = bus.pcpi_rd;
        if (bus.pcpi_wait) wait_bad++;
      end else begin
        if (!bus.pcpi_wait) wait_bad++;
        if (bus.pcpi_wr || bus.pcpi_rd != 0) quiet_bad++;
      end
      if (sp_we) begin
        we_n++;
        if (sp_addr !== rs1[7:0] || sp_wdata !== rs2[15:0]) addr_bad++;
      end
      if (sp_re) begin
        re_n++;
        if (sp_addr !== rs1[7:0]) addr_bad++;
      end
      if (eng_start) begin
        st_n++; op_seen = eng_op;
        if (done_dly > 0) done_at = cyc + done_dly;
      end
      if (cyc == done_at) eng_done = 1'b1;
    end
    eng_done = 1'b0;

    check_val("ready_seen", 32'(got), 32'd1);
    check_val("latency", lat, exp_lat);
    check_val("wr", 32'(wr_seen), 32'(exp_wr));
    check_val("rd", rd_seen, exp_rd);
    check_val("sp_we_count", we_n, exp_we);
    check_val("sp_re_count", re_n, exp_re);
    check_val("eng_start_count", st_n, exp_st);
    if (exp_st == 1) check_val("eng_op", 32'(op_seen), 32'(exp_op));
    check_val("wait_profile", wait_bad, 0);
    check_val("quiet_outputs", quiet_bad, 0);
    check_val("strobe_addr_data", addr_bad, 0);
    check_val("eng_dim", 32'(eng_dim), 32'(m_dim));

    // GUARD cycle with pcpi_valid still held, then drop valid and confirm no re-issue.
    step();
    check_val("guard_idle", {bus.pcpi_ready, bus.pcpi_wait, sp_we, sp_re, eng_start}, 0);
    step();
    bus.pcpi_valid = 1'b0;
    step();
    check_val("no_reissue", {bus.pcpi_ready, bus.pcpi_wait, sp_we, sp_re, eng_start}, 0);
  endtask

  task automatic run_unclaimed(input string tag, input logic [31:0] insn);
    int bad;
    bad = 0;
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = 32'd3;
    bus.pcpi_rs2   = 32'h55;
    repeat (6) begin
      step();
      if (bus.pcpi_wait || bus.pcpi_ready || sp_we || sp_re || eng_start) bad++;
    end
    check_val(tag, bad, 0);
    bus.pcpi_valid = 1'b0;
    step();
  endtask

  logic [2:0]  ops [6];
  logic [31:0] insn_tmp;
  logic [2:0]  f3r;
  logic [31:0] a;

  initial begin
    n_chk = 0;
    n_fail = 0;
    model_reset();
    ops[0] = C_CFG; ops[1] = C_LOAD; ops[2] = C_WEIGHT;
    ops[3] = C_COMPUTE; ops[4] = C_READ; ops[5] = C_STATUS;
    rst = 1'b1;
    eng_done = 1'b0;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = '0;
    bus.pcpi_rs1   = '0;
    bus.pcpi_rs2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {sp_we, sp_re, sp_addr, sp_wdata, eng_start, eng_op,
                                bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}, 0);
    check_val("reset_rd", bus.pcpi_rd, 0);
    check_val("reset_eng_dim", 32'(eng_dim), PE_DIM);
    rst = 1'b0;
    step();

    // Directed scenarios.
    run_op(C_LOAD, 32'd5, 32'h1234, 0);
    run_op(C_READ, 32'd5, 32'h0, 0);
    run_op(C_CFG, 32'd3, 32'h0, 0);
    run_op(C_STATUS, 32'd0, 32'h0, 0);
    run_op(C_CFG, 32'd9, 32'h0, 0);
    run_op(C_STATUS, 32'd0, 32'h0, 0);
    run_op(C_STATUS, 32'd0, 32'h0, 0);
    run_op(C_COMPUTE, 32'd0, 32'h0, 9);
    run_op(C_WEIGHT, 32'd0, 32'h0, 0);
    run_op(C_STATUS, 32'd0, 32'h0, 0);
    run_op(C_LOAD, 32'd300, 32'hBEEF, 0);
    run_op(C_READ, 32'd300, 32'h0, 0);
    run_op(C_STATUS, 32'd0, 32'h0, 0);
    run_op(C_WEIGHT, 32'd0, 32'h0, 16);

    insn_tmp = mk_insn(3'b011);
    run_unclaimed("unclaimed_f3_011", insn_tmp);
    insn_tmp = mk_insn(3'b111);
    run_unclaimed("unclaimed_f3_111", insn_tmp);
    insn_tmp = mk_insn(C_LOAD);
    insn_tmp[31:25] = 7'b0000010;
    run_unclaimed("wrong_funct7", insn_tmp);
    insn_tmp = mk_insn(C_LOAD);
    insn_tmp[6:0] = 7'b0110011;
    run_unclaimed("wrong_opcode", insn_tmp);

    // Stray eng_done while idle must not disturb anything.
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check_val("stray_done_idle", {bus.pcpi_wait, bus.pcpi_ready}, 0);
    run_op(C_COMPUTE, 32'd0, 32'h0, 3);
    run_op(C_STATUS, 32'd0, 32'h0, 0);

    // Async reset in the middle of an engine operation.
    run_op(C_CFG, 32'd2, 32'h0, 0);
    run_op(C_LOAD, 32'd300, 32'h1, 0);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk_insn(C_COMPUTE);
    bus.pcpi_rs1   = 32'd7;
    bus.pcpi_rs2   = 32'h0;
    repeat (6) step();
    check_val("pre_rst_busy", {bus.pcpi_wait, eng_op, sp_addr}, {1'b1, 1'b1, 8'd7});
    #3;
    rst = 1'b1;
    #1;
    check_val("rst_mid_eng_outputs", {sp_we, sp_re, sp_addr, sp_wdata, eng_start, eng_op,
                                      bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}, 0);
    check_val("rst_mid_eng_rd", bus.pcpi_rd, 0);
    check_val("rst_mid_eng_dim", 32'(eng_dim), PE_DIM);
    bus.pcpi_valid = 1'b0;
    model_reset();
    step();
    rst = 1'b0;
    step();
    run_op(C_STATUS, 32'd0, 32'h0, 0);
    run_op(C_LOAD, 32'd9, 32'hA5A5, 0);
    run_op(C_READ, 32'd9, 32'h0, 0);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      f3r = ops[$urandom_range(0, 5)];
      if (f3r == C_CFG)
        a = ($urandom_range(0, 9) == 0) ? 32'd260 : 32'($urandom_range(0, 6));
      else if (f3r == C_LOAD || f3r == C_READ)
        a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 400)) : 32'($urandom_range(0, 15));
      else
        a = $urandom;
      run_op(f3r, a, $urandom, int'($urandom_range(0, 20)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
